// File: rtl/r_channel_router.sv
// r_channel_router
//   AXI read-data return path: two slaves (S0, S1) to two masters (M0, M1).
//   A slave owns the path from grant until its RLAST beat handshakes. Grant
//   alternates round-robin between slaves. The destination master comes from
//   id[7:4] of the locked slave's live ID. Only id[3:0] is forwarded.
//   Beats carrying an unknown master code are sunk, and each one is flagged
//   on drop_o.
// Ports
//   clk, rst                 clock, async active-low reset
//   *_s0_i / *_s1_i          R channel from slaves (id 8b, data, resp, last, valid)
//   ready_s0_o / ready_s1_o  RREADY to slaves
//   *_m0_o / *_m1_o          R channel to masters (id 4b, data, resp, last, valid)
//   ready_m0_i / ready_m1_i  RREADY from masters
//   drop_o                   pulse per discarded beat
module r_channel_router (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  id_s0_i,
  input  logic [31:0] data_s0_i,
  input  logic [1:0]  resp_s0_i,
  input  logic        last_s0_i,
  input  logic        valid_s0_i,
  output logic        ready_s0_o,
  input  logic [7:0]  id_s1_i,
  input  logic [31:0] data_s1_i,
  input  logic [1:0]  resp_s1_i,
  input  logic        last_s1_i,
  input  logic        valid_s1_i,
  output logic        ready_s1_o,
  output logic [3:0]  id_m0_o,
  output logic [31:0] data_m0_o,
  output logic [1:0]  resp_m0_o,
  output logic        last_m0_o,
  output logic        valid_m0_o,
  input  logic        ready_m0_i,
  output logic [3:0]  id_m1_o,
  output logic [31:0] data_m1_o,
  output logic [1:0]  resp_m1_o,
  output logic        last_m1_o,
  output logic        valid_m1_o,
  input  logic        ready_m1_i,
  output logic        drop_o
);

  localparam logic [3:0] AXI_MASTER0 = 4'h1;
  localparam logic [3:0] AXI_MASTER1 = 4'h2;

  typedef enum logic [1:0] {IDLE, LOCK_S0, LOCK_S1} state_e;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        valid;
  } r_beat_t;

  state_e  state_q, state_d;
  logic    prio_s1_q, prio_s1_d;
  r_beat_t sel;
  logic    locked;
  logic    ready_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      prio_s1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_s1_q <= prio_s1_d;
    end
  end

  // Datapath: the locked slave is muxed straight to the decoded master.
  always_comb begin
    locked     = (state_q == LOCK_S0) || (state_q == LOCK_S1);
    sel        = (state_q == LOCK_S1) ?
                 '{id_s1_i, data_s1_i, resp_s1_i, last_s1_i, valid_s1_i} :
                 '{id_s0_i, data_s0_i, resp_s0_i, last_s0_i, valid_s0_i};
    ready_sel  = 1'b0;
    drop_o     = 1'b0;
    id_m0_o    = '0;
    data_m0_o  = '0;
    resp_m0_o  = '0;
    last_m0_o  = 1'b0;
    valid_m0_o = 1'b0;
    id_m1_o    = '0;
    data_m1_o  = '0;
    resp_m1_o  = '0;
    last_m1_o  = 1'b0;
    valid_m1_o = 1'b0;
    if (locked) begin
      case (sel.id[7:4])
        AXI_MASTER0: begin
          id_m0_o    = sel.id[3:0];
          data_m0_o  = sel.data;
          resp_m0_o  = sel.resp;
          last_m0_o  = sel.last;
          valid_m0_o = sel.valid;
          ready_sel  = ready_m0_i;
        end
        AXI_MASTER1: begin
          id_m1_o    = sel.id[3:0];
          data_m1_o  = sel.data;
          resp_m1_o  = sel.resp;
          last_m1_o  = sel.last;
          valid_m1_o = sel.valid;
          ready_sel  = ready_m1_i;
        end
        default: begin
          // Unknown owner: accept the beat so the slave never wedges.
          ready_sel = 1'b1;
          drop_o    = sel.valid;
        end
      endcase
    end
    ready_s0_o = (state_q == LOCK_S0) && ready_sel;
    ready_s1_o = (state_q == LOCK_S1) && ready_sel;
  end

  // Lock control: grant in IDLE, release on the RLAST handshake.
  always_comb begin
    state_d   = state_q;
    prio_s1_d = prio_s1_q;
    case (state_q)
      IDLE: begin
        if (valid_s0_i && valid_s1_i) state_d = prio_s1_q ? LOCK_S1 : LOCK_S0;
        else if (valid_s0_i)          state_d = LOCK_S0;
        else if (valid_s1_i)          state_d = LOCK_S1;
        // The slave just granted becomes the lower-priority one.
        if (state_d == LOCK_S0) prio_s1_d = 1'b1;
        if (state_d == LOCK_S1) prio_s1_d = 1'b0;
      end
      LOCK_S0, LOCK_S1: begin
        if (sel.valid && ready_sel && sel.last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
